// File: rtl/elevator_scheduler.sv
// Single-car elevator sequencer: latches floor calls, picks direction by collective (SCAN)
// scheduling, and times floor-to-floor travel and door dwell.
module elevator_scheduler #(
  parameter int unsigned N_FLOORS      = 4,
  parameter int unsigned FLOOR_W       = 2,
  parameter int unsigned TRAVEL_CYCLES = 50000000,
  parameter int unsigned DOOR_CYCLES   = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
  localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_CYCLES - 1);
  localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_CYCLES - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StMoveUp   = 2'd1;
  localparam logic [1:0] StMoveDown = 2'd2;
  localparam logic [1:0] StDoor     = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, floor_nxt;
  logic                dir_q, dir_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [N_FLOORS-1:0] pend_q, pend_d, req_any, clear_mask;
  logic                moving_q, door_q;
  logic                above, below, here, door_call, arrive_hit;

  assign req_any   = pend_q | call_req;
  assign floor_nxt = (state_q == StMoveUp) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  // Floor-relative views of the request set; loops keep indexing in range for any N_FLOORS.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    here       = 1'b0;
    door_call  = 1'b0;
    arrive_hit = 1'b0;
    for (int i = 0; i < int'(N_FLOORS); i++) begin
      if (i > int'(floor_q)) begin
        above = above | pend_q[i];
      end else if (i < int'(floor_q)) begin
        below = below | pend_q[i];
      end else begin
        here      = pend_q[i];
        door_call = call_req[i];
      end
      if (i == int'(floor_nxt)) arrive_hit = req_any[i];
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (here) begin
          state_d = StDoor;
        end else if (dir_q && above) begin
          state_d = StMoveUp;
        end else if (!dir_q && below) begin
          state_d = StMoveDown;
        end else if (above) begin
          state_d = StMoveUp;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = StMoveDown;
          dir_d   = 1'b0;
        end
      end
      StMoveUp, StMoveDown: begin
        if (timer_q == TravelLast) begin
          floor_d = floor_nxt;
          timer_d = '0;
          if (arrive_hit) state_d = StDoor;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDoor: begin
        if (door_call) begin
          timer_d = '0;
        end else if (timer_q == DoorLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serviced floor is cleared on door entry and held clear while open; clear beats set.
  always_comb begin
    clear_mask = '0;
    if (state_q == StDoor || state_d == StDoor) begin
      for (int i = 0; i < int'(N_FLOORS); i++) begin
        if (i == int'(floor_d)) clear_mask[i] = 1'b1;
      end
    end
    pend_d = req_any & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      timer_q  <= '0;
      pend_q   <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      moving_q <= (state_d == StMoveUp) || (state_d == StMoveDown);
      door_q   <= (state_d == StDoor);
    end
  end

  assign cur_floor = floor_q;
  assign dir_up    = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, each cycle checked
// against a countdown-based behavioural model of the car.
module tb_elevator_scheduler;
  localparam int N  = 4;
  localparam int FW = 2;
  localparam int T  = 4;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  call_req = '0;
  logic [FW-1:0] cur_floor;
  logic          dir_up, moving, door_open;
  logic [N-1:0]  pending;
  logic [FW+3+N-1:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 waiting, 1 travelling in m_dir, 2 door open; m_left counts cycles remaining.
  int m_floor, m_left, m_mode;
  bit m_dir;
  bit m_pend [N];

  elevator_scheduler #(
    .N_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .cur_floor(cur_floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  assign dut_vec = {cur_floor, dir_up, moving, door_open, pending};

  always @(negedge clk) begin
    if (rst_n === 1'b1)
      assert (int'(cur_floor) < N) else $error("FAIL floor_range got=%0d", cur_floor);
  end

  function automatic logic [FW+3+N-1:0] model_vec();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    return {FW'(m_floor), m_dir, m_mode == 1, m_mode == 2, p};
  endfunction

  function automatic void model_step(input logic [N-1:0] c, input logic r);
    bit nxt [N];
    bit above, below, was_door;
    if (!r) begin
      m_floor = 0; m_dir = 1'b1; m_mode = 0; m_left = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      return;
    end
    was_door = (m_mode == 2);
    for (int i = 0; i < N; i++) nxt[i] = m_pend[i] | c[i];
    case (m_mode)
      0: begin
        above = 1'b0; below = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (i > m_floor) above |= m_pend[i];
          if (i < m_floor) below |= m_pend[i];
        end
        if (m_pend[m_floor]) begin
          m_mode = 2; m_left = D;
        end else if (above && (m_dir || !below)) begin
          m_dir = 1'b1; m_mode = 1; m_left = T;
        end else if (below) begin
          m_dir = 1'b0; m_mode = 1; m_left = T;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir ? 1 : -1;
          if (nxt[m_floor]) begin m_mode = 2; m_left = D; end
          else m_left = T;
        end
      end
      default: begin
        if (c[m_floor]) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    if (was_door || m_mode == 2) nxt[m_floor] = 1'b0;
    m_pend = nxt;
  endfunction

  task automatic tick(input logic [N-1:0] c, input logic r);
    call_req = c;
    rst_n    = r;
    @(posedge clk);
    model_step(c, r);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      tick(4'b1111, 1'b0);
      total++;
      if (dut_vec !== 9'b00_1_0_0_0000) begin
        bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 9'b00_1_0_0_0000);
      end
    end
    tick(4'b1111, 1'b1);
    total++;
    if (pending !== 4'b1111) begin
      bad++; $display("FAIL reset_release_pending got=%b exp=1111", pending);
    end
    for (int k = 0; k < 60; k++) begin
      tick(4'b0000, 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL reset_drain k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_single_trip();
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      tick(4'b0000, 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL trip_model k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
      if (k == 1) begin
        total++;
        if (moving !== 1'b1) begin bad++; $display("FAIL trip_start got=%b exp=1", moving); end
      end
      if (k == 5) begin
        total++;
        if (cur_floor !== 2'd1) begin bad++; $display("FAIL trip_floor1 got=%0d exp=1", cur_floor); end
      end
      if (k == 9) begin
        total++;
        if ({cur_floor, door_open, moving, pending[2]} !== 5'b10_1_0_0) begin
          bad++; $display("FAIL trip_arrive got=%b exp=10100",
                          {cur_floor, door_open, moving, pending[2]});
        end
      end
      if (k == 12) begin
        total++;
        if ({door_open, moving} !== 2'b00) begin
          bad++; $display("FAIL trip_close got=%b exp=00", {door_open, moving});
        end
      end
    end
  endtask

  task automatic test_pickup();
    int stops[$];
    logic prev_door = 1'b0;
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b1000, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      tick((k == 3) ? 4'b0010 : 4'b0000, 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL pickup_model k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
      if (door_open === 1'b1 && prev_door !== 1'b1) stops.push_back(int'(cur_floor));
      prev_door = door_open;
    end
    total++;
    if (stops.size() != 2 || stops[0] != 1 || stops[1] != 3 || pending !== 4'b0000) begin
      bad++; $display("FAIL pickup_stops got=%p pend=%b exp='{1,3} pend=0000", stops, pending);
    end
  endtask

  task automatic test_direction();
    int fseq[$];
    int dseq[$];
    logic [FW-1:0] prev_floor;
    logic prev_door = 1'b0;
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b1);
    for (int k = 0; k < 12; k++) tick(4'b0000, 1'b1);
    total++;
    if ({cur_floor, dir_up, moving, door_open} !== 5'b10_1_0_0) begin
      bad++; $display("FAIL dir_setup got=%b exp=10100", {cur_floor, dir_up, moving, door_open});
    end
    tick(4'b1001, 1'b1);
    prev_floor = cur_floor;
    for (int k = 0; k < 60; k++) begin
      tick(4'b0000, 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL dir_model k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
      if (cur_floor !== prev_floor) fseq.push_back(int'(cur_floor));
      if (door_open === 1'b1 && prev_door !== 1'b1) dseq.push_back(int'(cur_floor));
      prev_floor = cur_floor;
      prev_door  = door_open;
    end
    total++;
    if (fseq.size() != 4 || fseq[0] != 3 || fseq[1] != 2 || fseq[2] != 1 || fseq[3] != 0) begin
      bad++; $display("FAIL dir_floor_seq got=%p exp='{3,2,1,0}", fseq);
    end
    total++;
    if (dseq.size() != 2 || dseq[0] != 3 || dseq[1] != 0 || dir_up !== 1'b0) begin
      bad++; $display("FAIL dir_doors got=%p dir=%b exp='{3,0} dir=0", dseq, dir_up);
    end
  endtask

  task automatic test_door_extend();
    int ext = 6;
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0010, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick((k == ext) ? 4'b0010 : 4'b0000, 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL extend_model k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
      if (k == 5 || k == ext + 2) begin
        total++;
        if (door_open !== 1'b1) begin bad++; $display("FAIL extend_open k=%0d got=%b exp=1", k, door_open); end
      end
      if (k == ext + 3) begin
        total++;
        if (door_open !== 1'b0) begin bad++; $display("FAIL extend_close got=%b exp=0", door_open); end
      end
      if (k >= 5) begin
        total++;
        if (pending[1] !== 1'b0) begin bad++; $display("FAIL extend_pend k=%0d got=%b exp=0", k, pending[1]); end
      end
    end
  endtask

  task automatic test_reset_mid_travel();
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b1);
    for (int k = 0; k < 7; k++) tick(4'b0000, 1'b1);
    total++;
    if ({cur_floor, moving} !== 3'b01_1) begin
      bad++; $display("FAIL midreset_setup got=%b exp=011", {cur_floor, moving});
    end
    tick(4'b1111, 1'b0);
    total++;
    if (dut_vec !== 9'b00_1_0_0_0000) begin
      bad++; $display("FAIL midreset_state got=%b exp=%b", dut_vec, 9'b00_1_0_0_0000);
    end
    tick(4'b0000, 1'b1);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL midreset_after got=%b exp=%b", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] c;
    logic r;
    for (int k = 0; k < 3000; k++) begin
      c = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
      r = ($urandom_range(0, 599) != 0);
      tick(c, r);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL random k=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_pickup();
    test_direction();
    test_door_extend();
    test_reset_mid_travel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Sequences a single elevator car across N_FLOORS floors.
- Latches floor call buttons into a pending-request register.
- Chooses travel direction using collective (SCAN) scheduling: it keeps the current direction while requests remain ahead.
- Times floor-to-floor travel and door dwell, and drives the car position/direction/door outputs consumed by the display and motor logic of elevator_controller.

Parameters:
- N_FLOORS, 4, number of floors served (floors 0..N_FLOORS-1), min 2.
- FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= N_FLOORS.
- TRAVEL_CYCLES, 50000000, clock cycles to move one floor, min 1.
- DOOR_CYCLES, 100000000, clock cycles door stays open, min 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- call_req  input  N_FLOORS  call buttons, bit i = floor i; level sampled every cycle; already synchronised upstream.
- cur_floor  output  FLOOR_W  current car floor index.
- dir_up  output  1  1 = last/current travel direction up, 0 = down.
- moving  output  1  1 while in MOVE_UP or MOVE_DOWN.
- door_open  output  1  1 while in DOOR_OPEN.
- pending  output  N_FLOORS  registered outstanding requests.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0, timer=0.
  - Reset mid-travel or mid-door aborts immediately. There is no position recovery: the car is at floor 0.
- All outputs are registered. moving and door_open are decoded from registered state.
- Timer width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1). It counts up from 0.
- pending update each edge: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask = one-hot(cur_floor) on the edge entering DOOR_OPEN and every edge while in DOOR_OPEN.
  - Clear wins over a simultaneous set for that floor.
- Let above = |pending[N_FLOORS-1:cur_floor+1], below = |pending[cur_floor-1:0], here = pending[cur_floor]. These use the registered pending only; a call arriving on the same edge is not seen until the next cycle.
- IDLE:
  - If here: go to DOOR_OPEN.
  - Else if dir_up and above: go to MOVE_UP.
  - Else if !dir_up and below: go to MOVE_DOWN.
  - Else if above: go to MOVE_UP, dir_up<=1.
  - Else if below: go to MOVE_DOWN, dir_up<=0.
  - Else stay in IDLE.
  - Timer is cleared on every exit.
- MOVE_UP / MOVE_DOWN:
  - Timer increments each cycle.
  - When timer==TRAVEL_CYCLES-1: cur_floor +/-1 and timer<=0.
  - On that same edge, evaluate the new floor using pending | call_req for that floor. If set, go to DOOR_OPEN. Otherwise continue in the same direction, with the timer restarted.
  - Continuing is always legal: a request ahead still exists, because pending is cleared only in DOOR_OPEN.
  - cur_floor never leaves 0..N_FLOORS-1. The bench asserts this.
- DOOR_OPEN:
  - pending[cur_floor] is held cleared and the timer increments.
  - If call_req[cur_floor]=1 during DOOR_OPEN, the timer restarts at 0 (door reopen/extend).
  - When timer==DOOR_CYCLES-1 with no call at this floor: go to IDLE. dir_up is unchanged.
- Latency:
  - Call sampled at edge t while IDLE: pending visible after t; move starts at t+1.
  - Each floor is reached TRAVEL_CYCLES edges after the previous one.
  - door_open asserts on the arrival edge and lasts exactly DOOR_CYCLES cycles if not extended.
  - One IDLE cycle occurs after every door close.
- Simultaneous calls above and below while IDLE: the current dir_up wins. With no calls in that direction, the car reverses.
- Calls for floors passed in the current direction stay pending until the car reverses.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=3, N_FLOORS=4):
1. Reset: hold rst_n=0 for 2 cycles with call_req=4'b1111 → cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0. Release → pending=4'b1111 one edge later.
2. Single up trip: pulse call_req[2] at edge t.
   - moving=1 from t+1.
   - cur_floor=1 at t+5, cur_floor=2 at t+9, together with door_open=1, moving=0, pending[2]=0.
   - door_open=0 and IDLE at t+12.
3. Pickup en route: from floor 0, request floor 3; pulse call_req[1] 2 cycles into the first travel → car stops at floor 1 (door 3 cycles), then continues to 3. pending ends 0.
4. Direction priority: car at floor 2, dir_up=1, IDLE, pending={0,3} set same cycle → goes up to 3 first, then down to 0 (dir_up=0). Floor sequence 3,2,1,0.
5. Door extend: at floor 1 in DOOR_OPEN, assert call_req[1] on door cycle 2 → door_open stays high 3 more cycles from that edge; pending[1] remains 0.
6. Reset mid-travel: assert rst_n=0 while moving between floors 1 and 2 → next edge cur_floor=0, moving=0, pending=0, state IDLE.
